audio_out_arbiter: RTL and testbench



---
 rtl/audio_out_arbiter_if.sv | 42 ++++
 rtl/audio_out_arbiter.sv | 116 +++++++++++
 tb/tb_audio_out_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_out_arbiter_if.sv
// ============================================================================
// audio_out_arbiter_if : producer / DAC-path signal bundle for audio_out_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface audio_out_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_left;
  logic [DATA_W-1:0] req0_right;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_left;
  logic [DATA_W-1:0] req1_right;
  logic              req1_ready;
  logic              mute;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] left_channel_audio_out;
  logic [DATA_W-1:0] right_channel_audio_out;
  logic [1:0]        grant;
  logic [CNT_W-1:0]  sample_count;

  modport master (
    output req0_valid, req0_left, req0_right, req1_valid, req1_left, req1_right,
           mute, audio_out_allowed,
    input  req0_ready, req1_ready, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, grant, sample_count
  );

  modport slave (
    input  req0_valid, req0_left, req0_right, req1_valid, req1_left, req1_right,
           mute, audio_out_allowed,
    output req0_ready, req1_ready, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, grant, sample_count
  );
endinterface

`default_nettype wire

// File: rtl/audio_out_arbiter.sv
// ============================================================================
// audio_out_arbiter : round-robin sharing of the Audio_Controller output path
// Optional mixing of simultaneous requests: define AUDIO_ARB_MIX_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module audio_out_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire               CLOCK_50,
  input  wire               reset,
  audio_out_arbiter_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q;
  logic              last_q, last_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q;

  logic w_empty, w_any, w_pick1, w_mix;

  assign w_empty = (state_q == S_EMPTY);
  assign w_any   = bus.req0_valid | bus.req1_valid;
  // Requester 1 wins when alone, or when both ask and requester 0 went last.
  assign w_pick1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

`ifdef AUDIO_ARB_MIX_EN
  logic signed [DATA_W-1:0] w_mix_left, w_mix_right;
  assign w_mix       = bus.req0_valid & bus.req1_valid;
  // Halving each input first keeps the sum inside DATA_W.
  assign w_mix_left  = ($signed(bus.req0_left)  >>> 1) + ($signed(bus.req1_left)  >>> 1);
  assign w_mix_right = ($signed(bus.req0_right) >>> 1) + ($signed(bus.req1_right) >>> 1);
`else
  assign w_mix = 1'b0;
`endif

  assign bus.req0_ready = w_empty & bus.req0_valid & (~w_pick1 | w_mix);
  assign bus.req1_ready = w_empty & bus.req1_valid & ( w_pick1 | w_mix);

  assign bus.write_audio_out         = (state_q == S_FULL) & bus.audio_out_allowed;
  assign bus.left_channel_audio_out  = left_q;
  assign bus.right_channel_audio_out = right_q;
  assign bus.grant                   = grant_q;
  assign bus.sample_count            = cnt_q;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef AUDIO_ARB_MIX_EN
    if (w_mix) begin
      left_d  = w_mix_left;
      right_d = w_mix_right;
      grant_d = 2'b11;
    end else
`endif
    if (w_pick1) begin
      left_d  = bus.req1_left;
      right_d = bus.req1_right;
      grant_d = 2'b10;
      last_d  = 1'b1;
    end else begin
      left_d  = bus.req0_left;
      right_d = bus.req0_right;
      grant_d = 2'b01;
      last_d  = 1'b0;
    end
    if (bus.mute) begin
      left_d  = '0;
      right_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      last_q  <= 1'b1;
      left_q  <= '0;
      right_q <= '0;
      grant_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_any) begin
            state_q <= S_FULL;
            left_q  <= left_d;
            right_q <= right_d;
            grant_q <= grant_d;
            last_q  <= last_d;
          end
        end
        S_FULL: begin
          if (bus.audio_out_allowed) begin
            state_q <= S_EMPTY;
            grant_q <= 2'b00;
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_out_arbiter.sv
// ============================================================================
// tb_audio_out_arbiter : directed self-checking bench for audio_out_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_audio_out_arbiter;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [CNT_W-1:0] exp_cnt;

  audio_out_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  audio_out_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_left = '0; bus.req0_right = '0;
    bus.req1_valid = 1'b0; bus.req1_left = '0; bus.req1_right = '0;
    bus.mute = 1'b0; bus.audio_out_allowed = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.write_audio_out !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
        bus.grant !== 2'b00 || bus.sample_count !== '0 ||
        bus.left_channel_audio_out !== '0 || bus.right_channel_audio_out !== '0) begin
      errors++;
      $display("FAIL reset_state: wr=%b r0=%b r1=%b grant=%b cnt=%0d l=%0d r=%0d required all zero",
               bus.write_audio_out, bus.req0_ready, bus.req1_ready, bus.grant,
               bus.sample_count, bus.left_channel_audio_out, bus.right_channel_audio_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_left = 32'd10000000; bus.req0_right = 32'd10000000;
    bus.audio_out_allowed = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 || bus.write_audio_out !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: r0=%b r1=%b wr=%b required 1 0 0",
               bus.req0_ready, bus.req1_ready, bus.write_audio_out);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.write_audio_out !== 1'b1 || bus.grant !== 2'b01 ||
        bus.left_channel_audio_out !== 32'd10000000 || bus.right_channel_audio_out !== 32'd10000000 ||
        bus.req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_write: wr=%b grant=%b l=%0d r=%0d r0=%b required 1 01 10000000 10000000 0",
               bus.write_audio_out, bus.grant, bus.left_channel_audio_out,
               bus.right_channel_audio_out, bus.req0_ready);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (bus.sample_count !== exp_cnt || bus.write_audio_out !== 1'b0 || bus.grant !== 2'b00 ||
        bus.left_channel_audio_out !== 32'd10000000) begin
      errors++;
      $display("FAIL single_after: cnt=%0d wr=%b grant=%b l=%0d required %0d 0 00 10000000",
               bus.sample_count, bus.write_audio_out, bus.grant,
               bus.left_channel_audio_out, exp_cnt);
    end
  endtask

  task automatic test_round_robin();
    int n0, n1;
    logic exp1;
    n0 = 0; n1 = 0;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_left = 32'd111; bus.req0_right = 32'd112;
    bus.req1_valid = 1'b1; bus.req1_left = 32'd221; bus.req1_right = 32'd222;
    bus.audio_out_allowed = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp1 = (i % 2) == 1;
      checks++;
      if (bus.req0_ready !== !exp1 || bus.req1_ready !== exp1) begin
        errors++;
        $display("FAIL rr_ready[%0d]: r0=%b r1=%b required %b %b",
                 i, bus.req0_ready, bus.req1_ready, !exp1, exp1);
      end
      @(posedge clk); #1;
      if (bus.grant == 2'b01) n0++;
      if (bus.grant == 2'b10) n1++;
      checks++;
      if (bus.grant !== (exp1 ? 2'b10 : 2'b01) || bus.write_audio_out !== 1'b1 ||
          bus.left_channel_audio_out !== (exp1 ? 32'd221 : 32'd111) ||
          bus.right_channel_audio_out !== (exp1 ? 32'd222 : 32'd112)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: grant=%b wr=%b l=%0d r=%0d required %b 1 %0d %0d",
                 i, bus.grant, bus.write_audio_out, bus.left_channel_audio_out,
                 bus.right_channel_audio_out, exp1 ? 2'b10 : 2'b01,
                 exp1 ? 221 : 111, exp1 ? 222 : 112);
      end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1'b1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++;
    if (bus.sample_count !== 16'd8 || n0 != 4 || n1 != 4) begin
      errors++;
      $display("FAIL rr_totals: cnt=%0d n0=%0d n1=%0d required 8 4 4", bus.sample_count, n0, n1);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    int bad;
    bad = 0;
    @(negedge clk);
    bus.audio_out_allowed = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_left = 32'd5555; bus.req0_right = 32'd6666;
    @(posedge clk); #1;
    held = bus.left_channel_audio_out;
    bus.req1_valid = 1'b1; bus.req1_left = 32'd7777; bus.req1_right = 32'd8888;
    checks++;
    if (held !== 32'd5555 || bus.right_channel_audio_out !== 32'd6666) begin
      errors++;
      $display("FAIL bp_capture: l=%0d r=%0d required 5555 6666", held, bus.right_channel_audio_out);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.write_audio_out !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.left_channel_audio_out !== 32'd5555 || bus.right_channel_audio_out !== 32'd6666)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: bad_cycles=%0d required 0", bad);
    end
    bus.audio_out_allowed = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    checks++;
    if (bus.write_audio_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: wr=%b required 1", bus.write_audio_out);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.write_audio_out !== 1'b0 || bus.sample_count !== exp_cnt) begin
      errors++;
      $display("FAIL bp_one_write: wr=%b cnt=%0d required 0 %0d",
               bus.write_audio_out, bus.sample_count, exp_cnt);
    end
  endtask

  task automatic test_mute();
    @(negedge clk);
    bus.mute = 1'b1; bus.audio_out_allowed = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_left = -32'sd10000000; bus.req0_right = -32'sd10000000;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.write_audio_out !== 1'b1 || bus.left_channel_audio_out !== '0 ||
        bus.right_channel_audio_out !== '0) begin
      errors++;
      $display("FAIL mute_capture: wr=%b l=%0d r=%0d required 1 0 0", bus.write_audio_out,
               $signed(bus.left_channel_audio_out), $signed(bus.right_channel_audio_out));
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    bus.mute = 1'b0; bus.audio_out_allowed = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_left = -32'sd10000000; bus.req1_right = -32'sd10000000;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.mute = 1'b1;
    @(negedge clk);
    bus.audio_out_allowed = 1'b1;
    #1;
    checks++;
    if (bus.write_audio_out !== 1'b1 || bus.left_channel_audio_out !== -32'sd10000000 ||
        bus.right_channel_audio_out !== -32'sd10000000 || bus.grant !== 2'b10) begin
      errors++;
      $display("FAIL mute_late: wr=%b l=%0d r=%0d grant=%b required 1 -10000000 -10000000 10",
               bus.write_audio_out, $signed(bus.left_channel_audio_out),
               $signed(bus.right_channel_audio_out), bus.grant);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    bus.mute = 1'b0;
    checks++;
    if (bus.sample_count !== exp_cnt) begin
      errors++;
      $display("FAIL mute_count: cnt=%0d required %0d", bus.sample_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    int wr_seen;
    wr_seen = 0;
    @(negedge clk);
    bus.audio_out_allowed = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_left = 32'd4242; bus.req0_right = 32'd4343;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.write_audio_out !== 1'b0 || bus.grant !== 2'b00 || bus.sample_count !== '0 ||
        bus.left_channel_audio_out !== '0 || bus.right_channel_audio_out !== '0) begin
      errors++;
      $display("FAIL async_reset: wr=%b grant=%b cnt=%0d l=%0d r=%0d required all zero",
               bus.write_audio_out, bus.grant, bus.sample_count,
               bus.left_channel_audio_out, bus.right_channel_audio_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    bus.audio_out_allowed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.write_audio_out !== 1'b0) wr_seen++;
    end
    checks++;
    if (wr_seen != 0 || bus.sample_count !== '0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d cnt=%0d required 0 0", wr_seen, bus.sample_count);
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rr: r0=%b r1=%b required 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef AUDIO_ARB_MIX_EN
  task automatic test_mix();
    apply_reset();
    bus.audio_out_allowed = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_left = 32'd10000000; bus.req0_right = 32'd10000000;
    bus.req1_valid = 1'b1; bus.req1_left = -32'sd4000000; bus.req1_right = -32'sd4000000;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL mix_ready: r0=%b r1=%b required 1 1", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++;
    if (bus.grant !== 2'b11 || bus.left_channel_audio_out !== 32'd3000000 ||
        bus.right_channel_audio_out !== 32'd3000000 || bus.write_audio_out !== 1'b1) begin
      errors++;
      $display("FAIL mix_value: grant=%b l=%0d r=%0d wr=%b required 11 3000000 3000000 1",
               bus.grant, $signed(bus.left_channel_audio_out),
               $signed(bus.right_channel_audio_out), bus.write_audio_out);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mute();
    test_async_reset();
`ifdef AUDIO_ARB_MIX_EN
    test_mix();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
